serial_deser: RTL and testbench
===============================

# serial_deser

Serial-to-parallel receiver for the right-shift (LSB-first) serial link. It accepts one bit per qualified cycle on `sin` and assembles `WIDTH`-bit words, using `frame_start` to align word boundaries. Each completed word is presented on a registered valid/ready output port, with sticky flags for overrun and framing errors. It is the receive end paired with the parallel-load right-shift transmitter in the datapath.

## Interface
- `WIDTH`, default 16: word width in bits, ≥ 2.
- `CW`, default 4: counter width, equal to clog2(`WIDTH`).

- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `sin`, input, 1: serial data bit, LSB of each word first.
- `sin_valid`, input, 1: `sin` is a valid bit this cycle.
- `frame_start`, input, 1: word boundary marker; the bit presented in the same cycle, if any, is bit 0.
- `out_ready`, input, 1: consumer accepts `data_out` this cycle.
- `clr_err`, input, 1: clears the sticky error flags.
- `data_out`, output, `WIDTH`: last completed word (holding register).
- `out_valid`, output, 1: `data_out` holds an unconsumed word.
- `temp`, output, `WIDTH`: live shift register contents (debug).
- `bit_cnt`, output, `CW`: number of bits received in the current word.
- `busy`, output, 1: FSM is in SHIFT.
- `overrun`, output, 1: sticky; a word was overwritten before it was accepted.
- `frame_err`, output, 1: sticky; `frame_start` arrived mid-word.

## Operation
- FSM states are IDLE and SHIFT. `busy` = (state == SHIFT).
- In IDLE, `sin_valid` without `frame_start` is ignored: no shift, no count.
- Any state with `frame_start`=1:
  - `bit_cnt` is set to 0 and the FSM enters SHIFT.
  - If `sin_valid`=1 in the same cycle, that bit is shifted in and `bit_cnt` becomes 1.
- Shift operation: `temp` <= {`sin`, `temp`[WIDTH-1:1]}. With LSB-first input, `temp` equals the transmitted word after `WIDTH` shifts.
- In SHIFT with `sin_valid`=1 and no `frame_start`: shift, then `bit_cnt`++.
- Word completion: a shift occurs while `bit_cnt`==WIDTH-1.
  - `data_out` <= {`sin`, `temp`[WIDTH-1:1]}.
  - `out_valid` <= 1.
  - `bit_cnt` wraps to 0 and the FSM stays in SHIFT, so back-to-back words need no re-arm.
- `frame_start` while in SHIFT with `bit_cnt`≠0:
  - The partial word is discarded and `frame_err` is set.
  - The new frame then starts exactly as described above.
- Handshake:
  - `out_valid`=1 and `out_ready`=1 at an edge: the word is consumed and `out_valid` <= 0.
  - If a word completes on that same edge, `out_valid` stays 1 with the new data and no overrun is flagged.
  - A word completing while `out_valid`=1 and `out_ready`=0 overwrites `data_out`, sets `overrun`, and keeps `out_valid`=1.
- `data_out` changes only on word completion; it is not cleared by a handshake.
- `clr_err`=1 clears `overrun` and `frame_err`. If an error event occurs in the same cycle, the set wins.
- `sin_valid`=0 stalls the shift register and counter indefinitely; there is no timeout.

## Timing
- Reset (`rst`=0 at an edge), with all other inputs ignored:
  - state = IDLE.
  - `temp`=0, `data_out`=0, `bit_cnt`=0.
  - `out_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0.
- Reset mid-word drops the partial word and any pending `out_valid`.
- Every output is registered; there are no combinational paths from inputs to outputs.
- Latency: the last bit is sampled at edge N; `data_out`/`out_valid` are valid after edge N.
- Throughput: one bit per cycle; with `sin_valid` held high, one word every `WIDTH` cycles.
- `busy` rises after the edge that samples `frame_start` and stays high until reset.

## Test plan
- **Basic word:** reset, then pulse `frame_start` with the first bit. Send 0x00A3 LSB-first (1,1,0,0,0,1,0,1, then 8 zeros) with `sin_valid`=1 on consecutive cycles and `out_ready`=0.
  - Required: `out_valid`=1 and `data_out`=0x00A3 after the 16th edge; `bit_cnt`=0; `busy`=1.
- **Back-to-back with stalls:** send 0x1234 then 0xFFFF with no gap and `out_ready`=1, with `sin_valid` dropped for 3 cycles mid-word.
  - Required: `data_out`=0x1234 then 0xFFFF; each `out_valid` pulse lasts 1 cycle; `overrun`=0.
- **Overrun:** `out_ready`=0, send two words 0xAAAA and 0x5555.
  - Required: `data_out`=0x5555, `overrun`=1, `out_valid`=1.
  - Then `clr_err`=1 for 1 cycle: `overrun`=0.
- **Framing error:** after 5 bits of a word, assert `frame_start` with a new bit and send 0x8001.
  - Required: `frame_err`=1; `data_out`=0x8001 after 16 further bits (counting the `frame_start` bit).
- **Reset mid-word:** after 9 bits, hold `rst`=0 for 1 edge.
  - Required: all outputs are zero and FSM is IDLE.
  - `sin_valid` pulses without `frame_start` leave `bit_cnt`=0 and `temp`=0.
- **Same-edge handshake:** hold `out_ready`=1 while word 2 completes on the edge where word 1 is still pending.
  - Required: `out_valid` stays 1 with word 2's value; `overrun`=0.

Source files
------------

// File: rtl/serial_deser.sv
// LSB-first serial-to-parallel receiver with frame alignment, a registered
// valid/ready word output and sticky overrun / framing-error flags.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | not yet aligned; bits without frame_start are ignored
//   ST_SHIFT | aligned; every qualified bit is shifted in and counted
module serial_deser #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] temp,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic             shift_en;
  logic             complete;
  logic             ferr_ev;
  logic             ovr_ev;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    shift_en = sin_valid & (frame_start | (state_q == ST_SHIFT));
    shifted  = {sin, temp_q[WIDTH-1:1]};
    // A frame_start bit is always bit 0, so it can never complete a word.
    complete = shift_en & ~frame_start & (cnt_q == CNT_LAST);
    ferr_ev  = frame_start & (state_q == ST_SHIFT) & (cnt_q != '0);
    ovr_ev   = complete & valid_q & ~out_ready;
  end

  always_comb begin
    state_d = state_q;
    temp_d  = temp_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (frame_start) begin
      state_d = ST_SHIFT;
    end

    if (shift_en) begin
      temp_d = shifted;
    end

    if (frame_start) begin
      cnt_d = shift_en ? CW'(1) : '0;
    end else if (shift_en) begin
      cnt_d = complete ? '0 : cnt_q + CW'(1);
    end

    if (complete) begin
      data_d  = shifted;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Set beats clear when both happen on the same edge.
    ovr_d  = ovr_ev | (ovr_q & ~clr_err);
    ferr_d = ferr_ev | (ferr_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      temp_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign temp      = temp_q;
  assign bit_cnt   = cnt_q;
  assign busy      = (state_q == ST_SHIFT);
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: table of whole-word transfers, hand-written corner
// sequences, then random traffic, all shadowed by a per-cycle reference model.
module tb_serial_deser;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int VW = 2 * W + CW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sin = 1'b0;
  logic          sin_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic [W-1:0]  temp;
  logic [CW-1:0] bit_cnt;
  logic          busy;
  logic          overrun;
  logic          frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  serial_deser #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_err(clr_err),
    .data_out(data_out), .out_valid(out_valid), .temp(temp),
    .bit_cnt(bit_cnt), .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue holds the bits of the word being assembled.
  bit           m_armed = 1'b0;
  bit           bq[$];
  logic [W-1:0] m_temp = '0;
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_ferr = 1'b0;

  task automatic model_step(input logic r, input logic s, input logic sv,
                            input logic fs, input logic rdy, input logic clr);
    bit           done;
    bit           ferr_ev;
    bit           ovr_ev;
    logic [W-1:0] word;
    if (!r) begin
      m_armed = 1'b0; bq.delete(); m_temp = '0; m_data = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      return;
    end
    done    = 1'b0;
    word    = '0;
    ferr_ev = fs && m_armed && (bq.size() != 0);
    if (fs) begin
      bq.delete();
      m_armed = 1'b1;
    end
    if (sv && m_armed) begin
      bq.push_back(s);
      m_temp = (m_temp >> 1) | (W'(s) << (W - 1));
      if (bq.size() == W) begin
        foreach (bq[i]) word = word | (W'(bq[i]) << i);
        bq.delete();
        done = 1'b1;
      end
    end
    ovr_ev = done && m_valid && !rdy;
    if (done) begin
      m_data  = word;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ovr  = ovr_ev  || (m_ovr  && !clr);
    m_ferr = ferr_ev || (m_ferr && !clr);
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {data_out, out_valid, temp, bit_cnt, busy, overrun, frame_err};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_data, m_valid, m_temp, CW'(bq.size()), m_armed, m_ovr, m_ferr};
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic sv,
                     input logic fs, input logic rdy, input logic clr);
    rst = r; sin = s; sin_valid = sv; frame_start = fs; out_ready = rdy; clr_err = clr;
    model_step(r, s, sv, fs, rdy, clr);
    @(posedge clk);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic send(input logic [W-1:0] w, input int nbits, input logic fs0,
                      input logic rdy, input logic rdy_last, input int stall_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) repeat (3) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, rdy, 1'b0);
      cyc(1'b1, w[i], 1'b1, fs0 && (i == 0), (i == nbits - 1) ? rdy_last : rdy, 1'b0);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         fs;
    logic         rdy;
    logic         clr_first;
    int           stall_at;
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_ovr;
    logic         exp_ferr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{16'h00A3, 1'b1, 1'b0, 1'b0, -1, 16'h00A3, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'hAAAA, 1'b0, 1'b0, 1'b0, -1, 16'hAAAA, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h5555, 1'b0, 1'b0, 1'b0, -1, 16'h5555, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h1234, 1'b0, 1'b1, 1'b1,  7, 16'h1234, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 10, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_all_zero", dut_vec(), '0);

    foreach (tbl[k]) begin
      if (tbl[k].clr_first) begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, tbl[k].rdy, 1'b1);
        chk("clr_overrun", 40'(overrun), 40'(0));
      end
      send(tbl[k].word, W, tbl[k].fs, tbl[k].rdy, tbl[k].rdy, tbl[k].stall_at);
      chk("tbl_data",  40'(data_out),  40'(tbl[k].exp_data));
      chk("tbl_valid", 40'(out_valid), 40'(tbl[k].exp_valid));
      chk("tbl_ovr",   40'(overrun),   40'(tbl[k].exp_ovr));
      chk("tbl_ferr",  40'(frame_err), 40'(tbl[k].exp_ferr));
      chk("tbl_cnt",   40'(bit_cnt),   40'(0));
      chk("tbl_busy",  40'(busy),      40'(1));
    end

    // Word pulse with out_ready held is a single cycle; data holds.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pulse_len", 40'(out_valid), 40'(0));
    chk("data_hold", 40'(data_out),  40'(16'hFFFF));

    // Framing error: restart after 5 bits.
    send(16'h001F, 5, 1'b1, 1'b0, 1'b0, -1);
    chk("partial_cnt", 40'(bit_cnt), 40'(5));
    send(16'h8001, W, 1'b1, 1'b0, 1'b0, -1);
    chk("ferr_flag", 40'(frame_err), 40'(1));
    chk("ferr_data", 40'(data_out),  40'(16'h8001));
    chk("ferr_ovr",  40'(overrun),   40'(0));

    // Reset mid-word, then unaligned bits are ignored.
    send(16'h01FF, 9, 1'b1, 1'b1, 1'b1, -1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midreset_zero", dut_vec(), '0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_cnt",  40'(bit_cnt), 40'(0));
    chk("idle_temp", 40'(temp),    40'(0));
    chk("idle_busy", 40'(busy),    40'(0));

    // Same-edge handshake: word 2 completes as word 1 is accepted.
    send(16'h0F0F, W, 1'b1, 1'b0, 1'b0, -1);
    chk("w1_valid", 40'(out_valid), 40'(1));
    send(16'h3C3C, W, 1'b0, 1'b0, 1'b1, -1);
    chk("w2_valid", 40'(out_valid), 40'(1));
    chk("w2_data",  40'(data_out),  40'(16'h3C3C));
    chk("w2_ovr",   40'(overrun),   40'(0));

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 299) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0, 1'($urandom), $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
